// File: rtl/matvec_pkg.sv
// Shared constants and types for the matvec loader and the multiplier it feeds.
package matvec_pkg;

  localparam logic [7:0] HDR_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_K,
    LOAD_X,
    COMPUTE,
    DONE
  } state_e;

  // Multiplier latency in cen-high cycles: adder-tree depth plus the product stage.
  function automatic int lat(input int c);
    return $clog2(c) + 1;
  endfunction

endpackage

// File: rtl/matvec_loader.sv
// Byte-stream loader for the matrix-vector multiplier: parses a 0xA5-headed frame
// into packed k/x registers, then runs the multiplier's clock-enable long enough
// to flush its pipeline and flags when y is final.
module matvec_loader
  import matvec_pkg::*;
#(
  parameter int R   = 8,
  parameter int C   = 8,
  parameter int W_X = 8,
  parameter int W_K = 8
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic [7:0]                      rx_data,
  input  logic                            rx_valid,
  output logic [R-1:0][C-1:0][W_K-1:0]    k,
  output logic [C-1:0][W_X-1:0]           x,
  output logic                            cen,
  output logic                            y_valid,
  output logic                            busy,
  output logic                            overrun
);

  localparam int NK     = R * C;
  localparam int NX     = C;
  localparam int LAT    = lat(C);
  localparam int IDX_W  = $clog2(NK);
  localparam int XIDX_W = $clog2(NX);
  localparam int LAT_W  = $clog2(LAT + 1);

  state_e                   state_q;
  logic [IDX_W-1:0]         idx_q;
  logic [LAT_W-1:0]         latCnt_q;
  // Row-major flat storage; its packed layout is identical to the [R][C] view of k.
  logic [NK-1:0][W_K-1:0]   k_q;
  logic [NX-1:0][W_X-1:0]   x_q;
  logic                     cen_q;
  logic                     yValid_q;
  logic                     busy_q;
  logic                     overrun_q;

  assign k       = k_q;
  assign x       = x_q;
  assign cen     = cen_q;
  assign y_valid = yValid_q;
  assign busy    = busy_q;
  assign overrun = overrun_q;

  // Frame FSM: header detect, byte-indexed storage, timed cen burst, one-cycle y_valid.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      latCnt_q  <= '0;
      k_q       <= '0;
      x_q       <= '0;
      cen_q     <= 1'b0;
      yValid_q  <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      yValid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rx_valid && rx_data == HDR_BYTE) begin
            state_q   <= LOAD_K;
            idx_q     <= '0;
            overrun_q <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        LOAD_K: begin
          if (rx_valid) begin
            k_q[idx_q] <= rx_data;
            if (idx_q == IDX_W'(NK - 1)) begin
              state_q <= LOAD_X;
              idx_q   <= '0;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        LOAD_X: begin
          if (rx_valid) begin
            x_q[idx_q[XIDX_W-1:0]] <= rx_data;
            if (idx_q == IDX_W'(NX - 1)) begin
              state_q  <= COMPUTE;
              idx_q    <= '0;
              latCnt_q <= LAT_W'(LAT);
              cen_q    <= 1'b1;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        COMPUTE: begin
          if (rx_valid) begin
            overrun_q <= 1'b1;
          end
          latCnt_q <= latCnt_q - 1'b1;
          if (latCnt_q == LAT_W'(1)) begin
            state_q  <= DONE;
            cen_q    <= 1'b0;
            yValid_q <= 1'b1;
          end
        end
        DONE: begin
          if (rx_valid) begin
            overrun_q <= 1'b1;
          end
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          cen_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule
